// File: rtl/tape_audio_pkg.sv
// Shared types and helpers for the cassette-tape audio codec.
package tape_audio_pkg;

  localparam int TAPE_SAMPLE_W = 24;

  typedef logic signed [TAPE_SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    CHAN_L     = 2'd0,
    CHAN_R     = 2'd1,
    CHAN_AVG   = 2'd2,
    CHAN_L_ALT = 2'd3
  } chan_sel_e;

  typedef enum logic {
    CMP_LOW  = 1'b0,
    CMP_HIGH = 1'b1
  } cmp_state_e;

  // Signed add clamped to the range of a w-bit two's-complement value (w <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (w - 1));
    if (sum > hi)      return hi[31:0];
    else if (sum < lo) return lo[31:0];
    else               return sum[31:0];
  endfunction

endpackage

// File: rtl/synchroniser.sv
// Multi-flop level synchroniser for slow asynchronous control inputs.
// Latency LVLS cycles; no flow control.
module synchroniser #(
  parameter int WIDTH = 1,
  parameter int LVLS  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [LVLS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '{default: '0};
    end else begin
      stage[0] <= d;
      for (int i = 1; i < LVLS; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[LVLS-1];

endmodule

// File: rtl/tape_hyst_cmp.sv
// Hysteresis comparator with debounce; level flips after DEBOUNCE consecutive qualifying samples.
// Latency 1 cycle from the deciding sample; consumes one sample per sample_vld, never stalls.
module tape_hyst_cmp
  import tape_audio_pkg::*;
#(
  parameter int SAMPLE_W = 24,
  parameter int THR_HI   = 419430,
  parameter int THR_LO   = 209715,
  parameter int DEBOUNCE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sample_vld,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic                       level,
  output logic                       edge_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [0:0] ST_LOW  = CMP_LOW;
  localparam logic [0:0] ST_HIGH = CMP_HIGH;
  localparam logic signed [SAMPLE_W-1:0] HI = SAMPLE_W'(THR_HI);
  localparam logic signed [SAMPLE_W-1:0] LO = SAMPLE_W'(THR_LO);

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          qualify;

  always_comb begin
    qualify = (state == ST_LOW) ? (sample >= HI) : (sample < LO);
    cnt_inc = cnt + CW'(1);
  end

  // A non-qualifying sample (including one between thresholds) restarts the debounce run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOW;
      cnt        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      if (sample_vld) begin
        if (!qualify) begin
          cnt <= '0;
        end else if (cnt_inc == CW'(DEBOUNCE)) begin
          state      <= ~state;
          cnt        <= '0;
          edge_pulse <= 1'b1;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  assign level = (state == ST_HIGH);

endmodule

// File: rtl/tape_audio_if.sv
// Cobra1 cassette codec: ADC stream -> debounced tape level/edge/carrier; CPU drive -> slew-limited DAC.
// Level 1 cycle after the deciding sample; ADC always ready, DAC output held while dac_ready is low. Option: TAPE_DC_TRACK_EN.
module tape_audio_if
  import tape_audio_pkg::*;
#(
  parameter int SAMPLE_W  = 24,
  parameter int THR_HI    = 419430,
  parameter int THR_LO    = 209715,
  parameter int DEBOUNCE  = 2,
  parameter int CD_WINDOW = 4096,
  parameter int OUT_AMP   = 4194304,
  parameter int SLEW_STEP = 1048576,
  parameter int SYNC_LVLS = 4,
  parameter int DC_SHIFT  = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] adc_l_data,
  input  logic                       adc_l_valid,
  input  logic signed [SAMPLE_W-1:0] adc_r_data,
  input  logic                       adc_r_valid,
  output logic                       adc_ready,
  input  logic [1:0]                 chan_sel,
  output logic                       tape_in,
  output logic                       tape_edge,
  output logic                       carrier,
  input  logic                       tape_pos_async,
  input  logic                       tape_neg_async,
  output logic signed [SAMPLE_W-1:0] dac_data,
  output logic                       dac_valid,
  input  logic                       dac_ready
);

  localparam int CD_W = $clog2(CD_WINDOW + 1);
  localparam logic signed [SAMPLE_W:0] AMP_P  = (SAMPLE_W+1)'(OUT_AMP);
  localparam logic signed [SAMPLE_W:0] AMP_N  = (SAMPLE_W+1)'(-OUT_AMP);
  localparam logic signed [SAMPLE_W:0] STEP_P = (SAMPLE_W+1)'(SLEW_STEP);
  localparam logic signed [SAMPLE_W:0] STEP_N = (SAMPLE_W+1)'(-SLEW_STEP);

  logic                       run;
  logic signed [SAMPLE_W-1:0] l_reg, r_reg, l_cur, r_cur;
  logic signed [SAMPLE_W:0]   lr_sum, lr_avg;
  logic signed [SAMPLE_W-1:0] sample, cmp_sample;
  logic                       sample_evt;
  logic [CD_W-1:0]            cd_cnt, cd_inc;
  logic [1:0]                 drv_sync;
  logic signed [SAMPLE_W:0]   target_w, level_w, diff_w, next_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  assign adc_ready = run;
  assign dac_valid = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_reg <= '0;
      r_reg <= '0;
    end else begin
      if (adc_l_valid && run) l_reg <= adc_l_data;
      if (adc_r_valid && run) r_reg <= adc_r_data;
    end
  end

  // Averaging pairs the arriving sample with the other channel's latest value.
  always_comb begin
    l_cur  = adc_l_valid ? adc_l_data : l_reg;
    r_cur  = adc_r_valid ? adc_r_data : r_reg;
    lr_sum = {l_cur[SAMPLE_W-1], l_cur} + {r_cur[SAMPLE_W-1], r_cur};
    lr_avg = lr_sum >>> 1;
    case (chan_sel_e'(chan_sel))
      CHAN_R: begin
        sample_evt = adc_r_valid && run;
        sample     = adc_r_data;
      end
      CHAN_AVG: begin
        sample_evt = adc_l_valid && run;
        sample     = lr_avg[SAMPLE_W-1:0];
      end
      default: begin
        sample_evt = adc_l_valid && run;
        sample     = adc_l_data;
      end
    endcase
  end

`ifdef TAPE_DC_TRACK_EN
  // dc_acc holds the DC estimate scaled by 2^DC_SHIFT so the fractional residue is kept.
  logic signed [SAMPLE_W+DC_SHIFT-1:0] dc_acc;
  logic signed [SAMPLE_W-1:0]          dc;
  logic signed [SAMPLE_W:0]            dc_err;
  logic signed [31:0]                  s_ext, dc_neg, cmp_ext;

  always_comb begin
    dc         = dc_acc[SAMPLE_W+DC_SHIFT-1:DC_SHIFT];
    dc_err     = {sample[SAMPLE_W-1], sample} - {dc[SAMPLE_W-1], dc};
    s_ext      = {{(32-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    dc_neg     = -{{(32-SAMPLE_W){dc[SAMPLE_W-1]}}, dc};
    cmp_ext    = sat_add(s_ext, dc_neg, SAMPLE_W);
    cmp_sample = cmp_ext[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          dc_acc <= '0;
    else if (sample_evt) dc_acc <= dc_acc + {{(DC_SHIFT-1){dc_err[SAMPLE_W]}}, dc_err};
  end
`else
  assign cmp_sample = sample;
`endif

  tape_hyst_cmp #(
    .SAMPLE_W (SAMPLE_W),
    .THR_HI   (THR_HI),
    .THR_LO   (THR_LO),
    .DEBOUNCE (DEBOUNCE)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_vld (sample_evt),
    .sample     (cmp_sample),
    .level      (tape_in),
    .edge_pulse (tape_edge)
  );

  assign cd_inc = cd_cnt + CD_W'(1);

  // An edge takes priority over a window expiry landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_cnt  <= '0;
      carrier <= 1'b0;
    end else if (tape_edge) begin
      cd_cnt  <= '0;
      carrier <= 1'b1;
    end else if (sample_evt && (cd_cnt != CD_W'(CD_WINDOW))) begin
      cd_cnt <= cd_inc;
      if (cd_inc == CD_W'(CD_WINDOW)) carrier <= 1'b0;
    end
  end

  synchroniser #(
    .WIDTH (2),
    .LVLS  (SYNC_LVLS)
  ) u_drv_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({tape_pos_async, tape_neg_async}),
    .q     (drv_sync)
  );

  always_comb begin
    if (drv_sync[1])      target_w = AMP_P;
    else if (drv_sync[0]) target_w = AMP_N;
    else                  target_w = '0;
    level_w = {dac_data[SAMPLE_W-1], dac_data};
    diff_w  = target_w - level_w;
    if (diff_w > STEP_P)      next_w = level_w + STEP_P;
    else if (diff_w < STEP_N) next_w = level_w + STEP_N;
    else                      next_w = target_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      dac_data <= '0;
    else if (dac_valid && dac_ready) dac_data <= next_w[SAMPLE_W-1:0];
  end

endmodule

// File: tb/tb_tape_audio_if.sv
// Directed bench for tape_audio_if at default parameters; DC tracking scenario runs when TAPE_DC_TRACK_EN is defined.
module tb_tape_audio_if;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [23:0] adc_l_data = '0;
  logic               adc_l_valid = 1'b0;
  logic signed [23:0] adc_r_data = '0;
  logic               adc_r_valid = 1'b0;
  logic               adc_ready;
  logic [1:0]         chan_sel = 2'd0;
  logic               tape_in, tape_edge, carrier;
  logic               tape_pos_async = 1'b0;
  logic               tape_neg_async = 1'b0;
  logic signed [23:0] dac_data;
  logic               dac_valid;
  logic               dac_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int edge_cnt = 0;

  tape_audio_if dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .adc_l_data     (adc_l_data),
    .adc_l_valid    (adc_l_valid),
    .adc_r_data     (adc_r_data),
    .adc_r_valid    (adc_r_valid),
    .adc_ready      (adc_ready),
    .chan_sel       (chan_sel),
    .tape_in        (tape_in),
    .tape_edge      (tape_edge),
    .carrier        (carrier),
    .tape_pos_async (tape_pos_async),
    .tape_neg_async (tape_neg_async),
    .dac_data       (dac_data),
    .dac_valid      (dac_valid),
    .dac_ready      (dac_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (tape_edge) edge_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One sample on the chosen port, valid for exactly one clock; returns at the negedge after it is taken.
  task automatic send(input bit right, input int v);
    logic [31:0] vv;
    vv = v;
    @(negedge clk);
    if (right) begin adc_r_data = vv[23:0]; adc_r_valid = 1'b1; end
    else       begin adc_l_data = vv[23:0]; adc_l_valid = 1'b1; end
    @(negedge clk);
    adc_l_valid = 1'b0;
    adc_r_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if ({adc_ready, tape_in, tape_edge, carrier, dac_valid} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: rdy/in/edge/car/vld=%b expected 00000",
               {adc_ready, tape_in, tape_edge, carrier, dac_valid});
    end
    tests_run++;
    if (dac_data !== 24'sd0) begin
      tests_failed++;
      $display("FAIL reset_dac_data: got %0d expected 0", dac_data);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (adc_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_before_edge: got %b expected 0", adc_ready);
    end
    @(negedge clk);
    tests_run++;
    if ({adc_ready, dac_valid} !== 2'b11) begin
      tests_failed++;
      $display("FAIL ready_after_reset: rdy/vld=%b expected 11", {adc_ready, dac_valid});
    end
  endtask

  task automatic test_debounce();
    int e0;
    int   vals [3] = '{0, 500000, 500000};
    bit   exp  [3] = '{1'b0, 1'b0, 1'b1};
    e0 = edge_cnt;
    chan_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, vals[i]);
      tests_run++;
      if (tape_in !== exp[i]) begin
        tests_failed++;
        $display("FAIL debounce_level[%0d]: tape_in=%b expected %b", i, tape_in, exp[i]);
      end
    end
    tests_run++;
    if (tape_edge !== 1'b1) begin
      tests_failed++;
      $display("FAIL debounce_edge_pulse: tape_edge=%b expected 1", tape_edge);
    end
    @(negedge clk);
    tests_run++;
    if ({tape_edge, carrier} !== 2'b01 || edge_cnt - e0 != 1) begin
      tests_failed++;
      $display("FAIL debounce_after: edge/carrier=%b edges=%0d expected 01 and 1 edge",
               {tape_edge, carrier}, edge_cnt - e0);
    end
  endtask

  task automatic test_hysteresis();
    int e0;
    int vals [12] = '{-500000, -500000, 500000, 500000, -500000, -500000,
                      500000, 500000, 300000, 300000, 300000, 300000};
    bit exp  [12] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    e0 = edge_cnt;
    for (int i = 0; i < 12; i++) begin
      send(1'b0, vals[i]);
      tests_run++;
      if (tape_in !== exp[i]) begin
        tests_failed++;
        $display("FAIL hyst_level[%0d]: tape_in=%b expected %b", i, tape_in, exp[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (edge_cnt - e0 != 4) begin
      tests_failed++;
      $display("FAIL hyst_edges: got %0d expected 4", edge_cnt - e0);
    end
  endtask

  task automatic test_thresholds();
    int e0;
    int vals [14] = '{209715, 209715, 209715, 209714, 209714, 419429, 419429,
                      419429, 419430, 419430, -500000, 300000, -500000, -500000};
    bit exp  [14] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    e0 = edge_cnt;
    for (int i = 0; i < 14; i++) begin
      send(1'b0, vals[i]);
      tests_run++;
      if (tape_in !== exp[i]) begin
        tests_failed++;
        $display("FAIL thresh_level[%0d]: tape_in=%b expected %b", i, tape_in, exp[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (edge_cnt - e0 != 3) begin
      tests_failed++;
      $display("FAIL thresh_edges: got %0d expected 3", edge_cnt - e0);
    end
  endtask

  task automatic test_channels();
    bit [1:0] sel  [20] = '{0, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
    bit       port [20] = '{0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int       vals [20] = '{500000, 500000, -500000, -500000, 500000, 500000, 500000,
                            0, 600000, 600000, 600000, 400000, 600000, 600000,
                            -600000, -600000, -600000, 8388607, 8388607, 8388607};
    bit       exp  [20] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    for (int i = 0; i < 20; i++) begin
      chan_sel = sel[i];
      send(port[i], vals[i]);
      tests_run++;
      if (tape_in !== exp[i]) begin
        tests_failed++;
        $display("FAIL chan_level[%0d]: sel=%0d tape_in=%b expected %b", i, sel[i], tape_in, exp[i]);
      end
    end
    chan_sel = 2'd0;
  endtask

  task automatic test_carrier();
    send(1'b0, -500000);
    send(1'b0, -500000);
    @(negedge clk);
    tests_run++;
    if ({tape_in, carrier} !== 2'b01) begin
      tests_failed++;
      $display("FAIL carrier_after_edge: in/carrier=%b expected 01", {tape_in, carrier});
    end
    for (int i = 0; i < 4095; i++) send(1'b0, -500000);
    tests_run++;
    if (carrier !== 1'b1) begin
      tests_failed++;
      $display("FAIL carrier_at_4095: got %b expected 1", carrier);
    end
    send(1'b0, -500000);
    tests_run++;
    if (carrier !== 1'b0) begin
      tests_failed++;
      $display("FAIL carrier_at_4096: got %b expected 0", carrier);
    end
    repeat (3) send(1'b0, -500000);
    tests_run++;
    if (carrier !== 1'b0) begin
      tests_failed++;
      $display("FAIL carrier_saturated: got %b expected 0", carrier);
    end
    send(1'b0, 500000);
    send(1'b0, 500000);
    @(negedge clk);
    tests_run++;
    if ({tape_in, carrier} !== 2'b11) begin
      tests_failed++;
      $display("FAIL carrier_reassert: in/carrier=%b expected 11", {tape_in, carrier});
    end
  endtask

  task automatic test_dac();
    int up   [9] = '{0, 0, 0, 0, 1048576, 2097152, 3145728, 4194304, 4194304};
    int down [9] = '{3145728, 2097152, 1048576, 0, -1048576, -2097152, -3145728, -4194304, -4194304};
    logic [31:0] e;
    @(negedge clk);
    tape_pos_async = 1'b1;
    dac_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      e = up[i];
      tests_run++;
      if (dac_data !== e[23:0]) begin
        tests_failed++;
        $display("FAIL dac_ramp_up[%0d]: got %0d expected %0d", i, dac_data, up[i]);
      end
    end
    dac_ready = 1'b0;
    tape_pos_async = 1'b0;
    tape_neg_async = 1'b1;
    repeat (8) @(negedge clk);
    tests_run++;
    if (dac_data !== 24'sd4194304 || dac_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL dac_hold: data=%0d valid=%b expected 4194304 and 1", dac_data, dac_valid);
    end
    dac_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      e = down[i];
      tests_run++;
      if (dac_data !== e[23:0]) begin
        tests_failed++;
        $display("FAIL dac_ramp_down[%0d]: got %0d expected %0d", i, dac_data, down[i]);
      end
    end
    dac_ready = 1'b0;
    tape_pos_async = 1'b1;
    repeat (6) @(negedge clk);
    dac_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (dac_data !== -24'sd3145728) begin
      tests_failed++;
      $display("FAIL dac_pos_priority: got %0d expected -3145728", dac_data);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({adc_ready, tape_in, tape_edge, carrier, dac_valid} !== 5'b0 || dac_data !== 24'sd0) begin
      tests_failed++;
      $display("FAIL async_reset: rdy/in/edge/car/vld=%b data=%0d expected 00000 and 0",
               {adc_ready, tape_in, tape_edge, carrier, dac_valid}, dac_data);
    end
    tape_pos_async = 1'b0;
    tape_neg_async = 1'b0;
    dac_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (adc_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_rerelease: got %b expected 1", adc_ready);
    end
  endtask

`ifdef TAPE_DC_TRACK_EN
  task automatic test_dc_track();
    int e0;
    e0 = edge_cnt;
    chan_sel = 2'd0;
    send(1'b0, 1000000);
    send(1'b0, 1000000);
    tests_run++;
    if (tape_in !== 1'b1) begin
      tests_failed++;
      $display("FAIL dc_initial_rise: tape_in=%b expected 1", tape_in);
    end
    for (int i = 0; i < 3998; i++) send(1'b0, 1000000);
    @(negedge clk);
    tests_run++;
    if (tape_in !== 1'b0 || edge_cnt - e0 != 2) begin
      tests_failed++;
      $display("FAIL dc_converged: tape_in=%b edges=%0d expected 0 and 2", tape_in, edge_cnt - e0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_debounce();
    test_hysteresis();
    test_thresholds();
    test_channels();
    test_carrier();
    test_dac();
    test_async_reset();
`ifdef TAPE_DC_TRACK_EN
    test_dc_track();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
